// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential BCD-to-binary converter (reverse double dabble).
// Each SHIFT cycle shifts the {BCD, binary} scratch right by one bit and then
// subtracts 3 from every BCD nibble that ended up >= 8. After BIN_W shifts the
// binary field holds the value and the BCD field has drained to zero.
//
// Ports:
//   clk     - system clock, rising edge
//   rst     - asynchronous, active-high reset
//   start   - conversion request, only sampled while ready=1
//   bcd_in  - packed BCD input, digit 0 (ones) in [3:0]
//   bin_out - converted binary value, held until the next done
//   ready   - high in IDLE, start is accepted only then
//   done    - one-cycle pulse when bin_out/err update
//   err     - set with done when any input digit was > 9

// Per-nibble correction after the shift: a nibble that is >= 8 had a
// weight-10 carry shifted into it, subtracting 3 restores the decimal value.
// Modulo-16 and only applied at >= 8, so it can never underflow.
module bcd_nib_fix (
  input  logic [3:0] nib,
  output logic [3:0] fixed
);
  assign fixed = nib[3] ? (nib - 4'd3) : nib;
endmodule

module bcd_to_bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  ready,
  output logic                  done,
  output logic                  err
);
  localparam int BCD_W = 4*DIGITS;
  localparam int SCR_W = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t               state, state_nx;
  logic [SCR_W-1:0]     scratch, scratch_nx, shifted, corrected;
  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 inv, inv_nx;
  logic [BIN_W-1:0]     bin_nx;
  logic                 err_nx, done_nx;
  logic [DIGITS-1:0]    bad_dig;

  // Shift then correct every nibble of the BCD field in parallel.
  assign shifted = scratch >> 1;
  assign corrected[BIN_W-1:0] = shifted[BIN_W-1:0];

  genvar k;
  generate
    for (k = 0; k < DIGITS; k++) begin : g_dig
      bcd_nib_fix u_fix (
        .nib   (shifted[BIN_W+4*k +: 4]),
        .fixed (corrected[BIN_W+4*k +: 4])
      );
      assign bad_dig[k] = (bcd_in[4*k +: 4] > 4'd9);
    end
  endgenerate

  assign ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      scratch <= '0;
      cnt     <= '0;
      inv     <= 1'b0;
      bin_out <= '0;
      err     <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      scratch <= scratch_nx;
      cnt     <= cnt_nx;
      inv     <= inv_nx;
      bin_out <= bin_nx;
      err     <= err_nx;
      done    <= done_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    scratch_nx = scratch;
    cnt_nx     = cnt;
    inv_nx     = inv;
    bin_nx     = bin_out;
    err_nx     = err;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (|bad_dig) begin
            // Illegal digit: skip the shifting, report it from FINISH.
            inv_nx   = 1'b1;
            state_nx = FINISH;
          end else begin
            inv_nx     = 1'b0;
            scratch_nx = {bcd_in, {BIN_W{1'b0}}};
            cnt_nx     = '0;
            state_nx   = SHIFT;
          end
        end
      end
      SHIFT: begin
        scratch_nx = corrected;
        cnt_nx     = cnt + 1'b1;
        if (cnt == CNT_W'(BIN_W-1)) state_nx = FINISH;
      end
      FINISH: begin
        // Outputs are registered here, so done/bin_out/err appear together
        // in the cycle the FSM is back in IDLE.
        done_nx  = 1'b1;
        bin_nx   = inv ? '0 : scratch[BIN_W-1:0];
        err_nx   = inv;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed testbench for bcd_to_bin (DIGITS=4, BIN_W=14).
module tb_bcd_to_bin;
  logic        clk, rst, start;
  logic [15:0] bcd_in;
  logic [13:0] bin_out;
  logic        ready, done, err;

  int checks = 0;
  int errors = 0;

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .ready(ready), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for done, counting edges since the accept edge. Sampling is #1
  // after each rising edge; n=0 is the cycle right after acceptance.
  task automatic wait_done(output int n, output int low);
    n = 0; low = 0;
    while (!done && n < 40) begin
      if (!ready) low++;
      @(posedge clk); #1; n++;
    end
    if (!done) begin
      checks++; errors++;
      $error("FAIL done_timeout: observed no done expected done within 40 cycles");
    end
  endtask

  task automatic run(input string tag, input logic [15:0] bcd, input logic [13:0] exp_bin,
                     input logic exp_err, input int exp_lat);
    int n, low;
    @(posedge clk); #1;
    chk({tag, "_ready_idle"}, ready, 1);
    start = 1'b1; bcd_in = bcd;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n, low);
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_ready_low"}, low, exp_lat);
    chk({tag, "_bin"}, bin_out, exp_bin);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_ready_at_done"}, ready, 1);
    if (!exp_err) chk({tag, "_bcd_drained"}, dut.scratch[29:14], 0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int n, low, ndone;
    rst = 1'b1; start = 1'b0; bcd_in = '0;
    #2;
    chk("rst_bin", bin_out, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    #10 rst = 1'b0;

    run("zero", 16'h0000, 14'h0000, 1'b0, 15);
    run("max",  16'h9999, 14'h270F, 1'b0, 15);
    run("v1234", 16'h1234, 14'h04D2, 1'b0, 15);
    run("v0059", 16'h0059, 14'h003B, 1'b0, 15);
    run("bad", 16'h12A4, 14'h0000, 1'b1, 1);
    run("v0007", 16'h0007, 14'h0007, 1'b0, 15);

    // start/bcd_in activity while busy must be ignored.
    @(posedge clk); #1;
    start = 1'b1; bcd_in = 16'h4321;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      start = 1'b1; bcd_in = (i % 2 == 0) ? 16'h1111 : 16'h8888;
      @(posedge clk); #1; n++;
    end
    start = 1'b0; bcd_in = 16'h1111;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    chk("busy_latency", n, 15);
    chk("busy_bin", bin_out, 14'h10E1);
    chk("busy_err", err, 0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (done) ndone++; end
    chk("busy_single_done", ndone, 0);
    chk("busy_ready", ready, 1);

    // Asynchronous reset mid-conversion.
    start = 1'b1; bcd_in = 16'h0500;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_bin", bin_out, 0);
    chk("arst_ready", ready, 1);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    #2 rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (done) ndone++; end
    chk("arst_no_done", ndone, 0);
    run("v0500", 16'h0500, 14'h01F4, 1'b0, 15);

    // Continuous start: one conversion every 16 clocks.
    @(posedge clk); #1;
    start = 1'b1; bcd_in = 16'h0000;
    for (int k = 0; k <= 20; k++) begin
      n = 0;
      @(posedge clk); #1; n++;
      while (!done && n < 40) begin @(posedge clk); #1; n++; end
      chk($sformatf("stream%0d_period", k), n, 16);
      chk($sformatf("stream%0d_bin", k), bin_out, k);
      bcd_in = 16'(((k + 1) / 10) * 16 + ((k + 1) % 10));
    end
    start = 1'b0;
    @(posedge clk); #1;
    chk("stream_done_pulse", done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
